// File: rtl/stack_cmd_sequencer_if.sv
// ----------------------------------------------------------------------------
// stack_cmd_sequencer_if
//   Request/response handshake bundle between a requester and the stack
//   command sequencer.
//
//   Request channel (valid/ready):
//     REQ_VALID  requester -> sequencer   request present
//     REQ_READY  sequencer -> requester   sequencer can accept a request
//     REQ_OP     requester -> sequencer   0=nop, 1=push, 2=pop, 3=get
//     REQ_INDEX  requester -> sequencer   get depth, 0 = top of stack
//     REQ_DATA   requester -> sequencer   push data
//   Response channel (valid/ready):
//     RSP_VALID  sequencer -> requester   response present
//     RSP_READY  requester -> sequencer   response consumed
//     RSP_DATA   sequencer -> requester   pop/get result, 0 otherwise
//     RSP_ERR    sequencer -> requester   request was rejected
//
//   Modports: master = requester side, slave = sequencer side.
// ----------------------------------------------------------------------------
interface stack_cmd_sequencer_if #(
    parameter int DATA_W = 4
);
    logic              REQ_VALID;
    logic              REQ_READY;
    logic [1:0]        REQ_OP;
    logic [2:0]        REQ_INDEX;
    logic [DATA_W-1:0] REQ_DATA;
    logic              RSP_VALID;
    logic              RSP_READY;
    logic [DATA_W-1:0] RSP_DATA;
    logic              RSP_ERR;

    modport master (
        output REQ_VALID, REQ_OP, REQ_INDEX, REQ_DATA, RSP_READY,
        input  REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR
    );

    modport slave (
        input  REQ_VALID, REQ_OP, REQ_INDEX, REQ_DATA, RSP_READY,
        output REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR
    );
endinterface

// File: rtl/stack_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// stack_cmd_sequencer
//   Upstream controller for a DEPTH-entry circular stack. Accepts one
//   push/pop/get/nop request at a time, tracks stack occupancy, rejects
//   illegal requests before they reach the stack, drives the stack command
//   for exactly one cycle, captures the stack's registered read data and
//   returns one response per request.
//
//   Sequence per request: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE
//   (four cycles per request when the response is consumed immediately).
//
//   Ports:
//     CLK          clock, rising edge
//     RESET        asynchronous active-high reset (shared with the stack)
//     bus          request/response handshake (slave side)
//     COUNT        current stack occupancy, 0..DEPTH
//     FULL/EMPTY   COUNT==DEPTH / COUNT==0
//     STK_COMMAND  registered command to the stack (0 = idle)
//     STK_INDEX    registered get index to the stack
//     STK_DATA     registered push data to the stack
//     STK_Q        registered read data from the stack
// ----------------------------------------------------------------------------
module stack_cmd_sequencer #(
    parameter int DEPTH     = 5,
    parameter int DATA_W    = 4,
    parameter bit OVERWRITE = 1'b0
) (
    input  logic                   CLK,
    input  logic                   RESET,
    stack_cmd_sequencer_if.slave   bus,
    output logic [2:0]             COUNT,
    output logic                   FULL,
    output logic                   EMPTY,
    output logic [1:0]             STK_COMMAND,
    output logic [2:0]             STK_INDEX,
    output logic [DATA_W-1:0]      STK_DATA,
    input  logic [DATA_W-1:0]      STK_Q
);

    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    localparam logic [1:0] OP_NOP  = 2'd0;
    localparam logic [1:0] OP_PUSH = 2'd1;
    localparam logic [1:0] OP_POP  = 2'd2;
    localparam logic [1:0] OP_GET  = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t            state;
    logic [1:0]        op_p0;
    logic              err_p0;
    logic              req_ready;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_data;
    logic              req_err;

    // Legality check against the occupancy seen at the accept edge.
    function automatic logic req_illegal(input logic [1:0] op,
                                         input logic [2:0] idx,
                                         input logic [2:0] cnt);
        logic bad;
        bad = 1'b0;
        case (op)
            OP_PUSH: bad = !OVERWRITE && (cnt == DEPTH_C);
            OP_POP:  bad = (cnt == 3'd0);
            OP_GET:  bad = (idx >= cnt);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Occupancy saturates at DEPTH: a wrapping push replaces the oldest entry.
    function automatic logic [2:0] count_inc(input logic [2:0] cnt);
        return (cnt >= DEPTH_C) ? DEPTH_C : cnt + 3'd1;
    endfunction

    function automatic logic [2:0] count_dec(input logic [2:0] cnt);
        return (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
    endfunction

    assign req_err       = req_illegal(bus.REQ_OP, bus.REQ_INDEX, COUNT);

    assign bus.REQ_READY = req_ready;
    assign bus.RSP_VALID = rsp_valid;
    assign bus.RSP_DATA  = rsp_data;
    assign bus.RSP_ERR   = rsp_err;

    assign FULL  = (COUNT == DEPTH_C);
    assign EMPTY = (COUNT == 3'd0);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            op_p0       <= OP_NOP;
            err_p0      <= 1'b0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_data    <= '0;
            COUNT       <= 3'd0;
            STK_COMMAND <= OP_NOP;
            STK_INDEX   <= 3'd0;
            STK_DATA    <= '0;
        end else begin
            case (state)
                // IDLE: accept, classify, and stage the stack command so it
                // is visible to the stack for the whole ISSUE cycle.
                IDLE: begin
                    if (bus.REQ_VALID) begin
                        op_p0     <= bus.REQ_OP;
                        err_p0    <= req_err;
                        req_ready <= 1'b0;
                        if (!req_err && bus.REQ_OP != OP_NOP) begin
                            STK_COMMAND <= bus.REQ_OP;
                            STK_INDEX   <= bus.REQ_INDEX;
                            STK_DATA    <= bus.REQ_DATA;
                        end
                        state <= ISSUE;
                    end
                end

                // ISSUE: the stack executes at this closing edge; the
                // command drops back to idle so it lasts one cycle only.
                ISSUE: begin
                    STK_COMMAND <= OP_NOP;
                    STK_INDEX   <= 3'd0;
                    STK_DATA    <= '0;
                    if (!err_p0) begin
                        case (op_p0)
                            OP_PUSH: COUNT <= count_inc(COUNT);
                            OP_POP:  COUNT <= count_dec(COUNT);
                            default: COUNT <= COUNT;
                        endcase
                    end
                    state <= CAPTURE;
                end

                // CAPTURE: STK_Q now holds the stack's registered result.
                CAPTURE: begin
                    if (!err_p0 && (op_p0 == OP_POP || op_p0 == OP_GET)) begin
                        rsp_data <= STK_Q;
                    end else begin
                        rsp_data <= '0;
                    end
                    rsp_err   <= err_p0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end

                // RESP: hold the response until consumed; no bypass back
                // into a new request in the same cycle.
                RESP: begin
                    if (bus.RSP_READY) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_data  <= '0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_stack_cmd_sequencer
//   Drives two sequencers (OVERWRITE=0 and OVERWRITE=1) with identical
//   request streams. Each one is attached to its own behavioural circular
//   stack. Expected responses are queued when a request is driven and popped
//   when the corresponding response handshake occurs.
// ----------------------------------------------------------------------------
module tb_stack_cmd_sequencer;

    localparam int DW = 4;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] data;
    } rsp_t;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    logic          req_valid;
    logic [1:0]    req_op;
    logic [2:0]    req_index;
    logic [DW-1:0] req_data;
    logic          rsp_ready;

    stack_cmd_sequencer_if #(.DATA_W(DW)) bus0 ();
    stack_cmd_sequencer_if #(.DATA_W(DW)) bus1 ();

    assign bus0.REQ_VALID = req_valid;
    assign bus0.REQ_OP    = req_op;
    assign bus0.REQ_INDEX = req_index;
    assign bus0.REQ_DATA  = req_data;
    assign bus0.RSP_READY = rsp_ready;
    assign bus1.REQ_VALID = req_valid;
    assign bus1.REQ_OP    = req_op;
    assign bus1.REQ_INDEX = req_index;
    assign bus1.REQ_DATA  = req_data;
    assign bus1.RSP_READY = rsp_ready;

    logic [1:0][2:0]    cnt;
    logic [1:0]         full;
    logic [1:0]         empty;
    logic [1:0][1:0]    stk_cmd;
    logic [1:0][2:0]    stk_idx;
    logic [1:0][DW-1:0] stk_dat;
    logic [1:0][DW-1:0] stk_q;

    stack_cmd_sequencer #(.DEPTH(5), .DATA_W(DW), .OVERWRITE(1'b0)) dut0 (
        .CLK(CLK), .RESET(RESET), .bus(bus0),
        .COUNT(cnt[0]), .FULL(full[0]), .EMPTY(empty[0]),
        .STK_COMMAND(stk_cmd[0]), .STK_INDEX(stk_idx[0]), .STK_DATA(stk_dat[0]),
        .STK_Q(stk_q[0])
    );

    stack_cmd_sequencer #(.DEPTH(5), .DATA_W(DW), .OVERWRITE(1'b1)) dut1 (
        .CLK(CLK), .RESET(RESET), .bus(bus1),
        .COUNT(cnt[1]), .FULL(full[1]), .EMPTY(empty[1]),
        .STK_COMMAND(stk_cmd[1]), .STK_INDEX(stk_idx[1]), .STK_DATA(stk_dat[1]),
        .STK_Q(stk_q[1])
    );

    // Behavioural 5-entry circular stack: entry 0 is the top, a push into a
    // full stack drops the oldest entry, Q is registered.
    logic [DW-1:0] smem [2][5];

    always @(posedge CLK or posedge RESET) begin
        for (int i = 0; i < 2; i++) begin
            if (RESET) begin
                stk_q[i] <= '0;
                for (int k = 0; k < 5; k++) smem[i][k] <= '0;
            end else begin
                case (stk_cmd[i])
                    2'd1: begin
                        for (int k = 1; k < 5; k++) smem[i][k] <= smem[i][k-1];
                        smem[i][0] <= stk_dat[i];
                    end
                    2'd2: begin
                        stk_q[i] <= smem[i][0];
                        for (int k = 0; k < 4; k++) smem[i][k] <= smem[i][k+1];
                        smem[i][4] <= '0;
                    end
                    2'd3: begin
                        if (int'(stk_idx[i]) < 5) stk_q[i] <= smem[i][int'(stk_idx[i])];
                        else                      stk_q[i] <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Reference model of the sequencer's visible behaviour.
    logic [DW-1:0] rmem [2][5];
    int            rcnt [2];
    rsp_t          exp0 [$];
    rsp_t          exp1 [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            rcnt[i] = 0;
            for (int k = 0; k < 5; k++) rmem[i][k] = '0;
        end
        exp0.delete();
        exp1.delete();
    endtask

    // Instance 0 rejects a full push, instance 1 wraps.
    task automatic model_step(input int i, input logic [1:0] op, input logic [2:0] idx,
                              input logic [DW-1:0] d, output rsp_t e, output logic [1:0] cmd);
        logic err;
        err = (op == 2'd2 && rcnt[i] == 0) ||
              (op == 2'd3 && int'(idx) >= rcnt[i]) ||
              (op == 2'd1 && rcnt[i] == 5 && i == 0);
        e.err  = err;
        e.data = '0;
        cmd    = (err || op == 2'd0) ? 2'd0 : op;
        if (!err) begin
            case (op)
                2'd1: begin
                    for (int k = 4; k > 0; k--) rmem[i][k] = rmem[i][k-1];
                    rmem[i][0] = d;
                    if (rcnt[i] < 5) rcnt[i]++;
                end
                2'd2: begin
                    e.data = rmem[i][0];
                    for (int k = 0; k < 4; k++) rmem[i][k] = rmem[i][k+1];
                    rmem[i][4] = '0;
                    rcnt[i]--;
                end
                2'd3: e.data = rmem[i][int'(idx)];
                default: ;
            endcase
        end
    endtask

    // Response scoreboard: compare at the negedge preceding a handshake edge.
    always @(negedge CLK) begin
        rsp_t e;
        if (!RESET && bus0.RSP_VALID && rsp_ready) begin
            if (exp0.size() == 0) check("rsp0_unexpected", 1, 0);
            else begin
                e = exp0.pop_front();
                check("rsp0_err", bus0.RSP_ERR, e.err);
                check("rsp0_data", bus0.RSP_DATA, e.data);
            end
        end
        if (!RESET && bus1.RSP_VALID && rsp_ready) begin
            if (exp1.size() == 0) check("rsp1_unexpected", 1, 0);
            else begin
                e = exp1.pop_front();
                check("rsp1_err", bus1.RSP_ERR, e.err);
                check("rsp1_data", bus1.RSP_DATA, e.data);
            end
        end
    end

    task automatic check_state();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("count%0d", i), cnt[i], rcnt[i]);
            check($sformatf("full%0d", i), full[i], rcnt[i] == 5);
            check($sformatf("empty%0d", i), empty[i], rcnt[i] == 0);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(bus0.REQ_READY && bus1.REQ_READY) && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        check("idle_wait", n < 20, 1);
        check_state();
    endtask

    // Drives one request; returns #1 into CAPTURE unless wait_done is set.
    task automatic do_req(input logic [1:0] op, input logic [2:0] idx,
                          input logic [DW-1:0] d, input bit wait_done);
        rsp_t       e0, e1;
        logic [1:0] c0, c1;
        int         n;
        model_step(0, op, idx, d, e0, c0);
        model_step(1, op, idx, d, e1, c1);
        exp0.push_back(e0);
        exp1.push_back(e1);
        @(posedge CLK); #1;
        req_valid = 1'b1;
        req_op    = op;
        req_index = idx;
        req_data  = d;
        n = 0;
        while (!(bus0.REQ_READY && bus1.REQ_READY) && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        check("accept_wait", n < 20, 1);
        @(posedge CLK); #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_index = 3'($urandom);
        req_data  = DW'($urandom);
        check("issue_cmd0", stk_cmd[0], c0);
        check("issue_cmd1", stk_cmd[1], c1);
        if (c0 == 2'd1) check("issue_data0", stk_dat[0], d);
        if (c1 == 2'd1) check("issue_data1", stk_dat[1], d);
        if (c0 == 2'd3) check("issue_idx0", stk_idx[0], idx);
        @(posedge CLK); #1;
        check("capture_cmd0", stk_cmd[0], 0);
        check("capture_cmd1", stk_cmd[1], 0);
        if (wait_done) wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RESET     = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_index = 3'd0;
        req_data  = '0;
        rsp_ready = 1'b1;
        model_reset();

        repeat (3) @(posedge CLK);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_cmd%0d", i), stk_cmd[i], 0);
            check($sformatf("rst_stkdata%0d", i), stk_dat[i], 0);
            check($sformatf("rst_count%0d", i), cnt[i], 0);
        end
        check("rst_rsp_valid0", bus0.RSP_VALID, 0);
        check("rst_rsp_data0", bus0.RSP_DATA, 0);
        check("rst_rsp_err0", bus0.RSP_ERR, 0);
        RESET = 1'b0;
        @(posedge CLK); #1;
        check("rst_ready0", bus0.REQ_READY, 1);
        check("rst_ready1", bus1.REQ_READY, 1);
        check_state();

        // pushes, gets, pops, underflow
        do_req(2'd1, 3'd0, 4'h3, 1);
        do_req(2'd1, 3'd0, 4'h7, 1);
        do_req(2'd1, 3'd0, 4'hA, 1);
        do_req(2'd0, 3'd0, 4'h0, 1);
        do_req(2'd3, 3'd0, 4'h0, 1);
        do_req(2'd3, 3'd2, 4'h0, 1);
        do_req(2'd3, 3'd3, 4'h0, 1);
        for (int k = 0; k < 4; k++) do_req(2'd2, 3'd0, 4'h0, 1);

        // fill, push when full, then drain past empty
        for (int k = 1; k <= 5; k++) do_req(2'd1, 3'd0, 4'(k), 1);
        do_req(2'd3, 3'd4, 4'h0, 1);
        do_req(2'd1, 3'd0, 4'h6, 1);
        for (int k = 0; k < 6; k++) do_req(2'd2, 3'd0, 4'h0, 1);

        // backpressure on a pop response
        do_req(2'd1, 3'd0, 4'h9, 1);
        rsp_ready = 1'b0;
        do_req(2'd2, 3'd0, 4'h0, 0);
        for (int k = 0; k < 6; k++) begin
            @(posedge CLK); #1;
            check("bp_valid0", bus0.RSP_VALID, 1);
            check("bp_valid1", bus1.RSP_VALID, 1);
            check("bp_data0", bus0.RSP_DATA, 4'h9);
            check("bp_data1", bus1.RSP_DATA, 4'h9);
            check("bp_ready0", bus0.REQ_READY, 0);
        end
        rsp_ready = 1'b1;
        @(posedge CLK); #1;
        check("bp_release_ready0", bus0.REQ_READY, 1);
        check("bp_release_ready1", bus1.REQ_READY, 1);
        check("bp_release_valid0", bus0.RSP_VALID, 0);
        check_state();

        // reset during CAPTURE of a pop with two entries
        do_req(2'd1, 3'd0, 4'hB, 1);
        do_req(2'd1, 3'd0, 4'hC, 1);
        do_req(2'd2, 3'd0, 4'h0, 0);
        RESET = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("mid_rst_cmd%0d", i), stk_cmd[i], 0);
            check($sformatf("mid_rst_count%0d", i), cnt[i], 0);
            check($sformatf("mid_rst_empty%0d", i), empty[i], 1);
        end
        check("mid_rst_rsp_valid0", bus0.RSP_VALID, 0);
        check("mid_rst_rsp_valid1", bus1.RSP_VALID, 0);
        check("mid_rst_rsp_data0", bus0.RSP_DATA, 0);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge CLK); #1;
            check("post_rst_no_rsp0", bus0.RSP_VALID, 0);
            check("post_rst_no_rsp1", bus1.RSP_VALID, 0);
        end
        do_req(2'd2, 3'd0, 4'h0, 1);

        repeat (2) @(posedge CLK);
        #1;
        check("exp0_drained", exp0.size(), 0);
        check("exp1_drained", exp1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
